ecc_apb_master: RTL and testbench

Upstream command sequencer for the ECC encoder/decoder. Accepts one ECC job per valid/ready handshake and drives the APB write sequence (DATA_IN, CODEWORD_WIDTH, NOISE, CTRL) into the ECC block. It then waits for `operation_done`, captures `data_out` and `num_of_errors`, and returns them on a valid/ready response port. It replaces hand-driven APB stimulus whenever the ECC block is embedded in a larger datapath.

---
 rtl/ecc_apb_master_if.sv | 41 ++++
 rtl/ecc_apb_master.sv | 172 +++++++++++++++++
 tb/tb_ecc_apb_master.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ecc_apb_master_if.sv
// Bundle of the job command port, APB write bus, ECC completion inputs and response port
// that connects ecc_apb_master to its environment.
interface ecc_apb_master_if #(
   parameter int DATA_WIDTH      = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32
);
   logic                       cmd_valid;
   logic                       cmd_ready;
   logic [1:0]                 cmd_op;
   logic [1:0]                 cmd_width;
   logic [AMBA_WORD-1:0]       cmd_data;
   logic [AMBA_WORD-1:0]       cmd_noise;
   logic [AMBA_ADDR_WIDTH-1:0] PADDR;
   logic [AMBA_WORD-1:0]       PWDATA;
   logic                       PENABLE;
   logic                       PSEL;
   logic                       PWRITE;
   logic                       operation_done;
   logic [DATA_WIDTH-1:0]      data_out;
   logic [1:0]                 num_of_errors;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [DATA_WIDTH-1:0]      rsp_data;
   logic [1:0]                 rsp_errors;
   logic                       rsp_timeout;

   modport master (
      input  cmd_valid, cmd_op, cmd_width, cmd_data, cmd_noise,
      input  operation_done, data_out, num_of_errors, rsp_ready,
      output cmd_ready, PADDR, PWDATA, PENABLE, PSEL, PWRITE,
      output rsp_valid, rsp_data, rsp_errors, rsp_timeout
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_width, cmd_data, cmd_noise,
      output operation_done, data_out, num_of_errors, rsp_ready,
      input  cmd_ready, PADDR, PWDATA, PENABLE, PSEL, PWRITE,
      input  rsp_valid, rsp_data, rsp_errors, rsp_timeout
   );
endinterface

// File: rtl/ecc_apb_master.sv
// Sequences one ECC job: APB writes DATA_IN, CODEWORD_WIDTH, NOISE, CTRL, waits for completion,
// returns the result. Define ECC_APB_MASTER_TIMEOUT_EN to add the WAIT_DONE watchdog.
module ecc_apb_master #(
   parameter int DATA_WIDTH      = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input logic             clk,
   input logic             rst,
   ecc_apb_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

   state_t                     state_q, state_d;
   logic [1:0]                 idx_q, idx_d;
   logic [1:0]                 op_q, op_d, width_q, width_d;
   logic [AMBA_WORD-1:0]       data_q, data_d, noise_q, noise_d;
   logic                       cmd_ready_q, cmd_ready_d;
   logic                       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
   logic [1:0]                 rsp_errors_q, rsp_errors_d;

`ifdef ECC_APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   assign bus.rsp_timeout = rsp_timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign bus.rsp_timeout    = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      op_d         = op_q;
      width_d      = width_q;
      data_d       = data_q;
      noise_d      = noise_q;
      rsp_data_d   = rsp_data_q;
      rsp_errors_d = rsp_errors_q;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
      cnt_d         = cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: if (bus.cmd_valid) begin
            op_d    = bus.cmd_op;
            width_d = bus.cmd_width;
            data_d  = bus.cmd_data;
            noise_d = bus.cmd_noise;
            idx_d   = 2'd0;
            state_d = SETUP;
         end
         SETUP: state_d = ACCESS;
         ACCESS: if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = SETUP;
         end else begin
            state_d = WAIT_DONE;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT_DONE: if (bus.operation_done) begin
            rsp_data_d   = bus.data_out;
            rsp_errors_d = bus.num_of_errors;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
            state_d      = RESP;
         end
`ifdef ECC_APB_MASTER_TIMEOUT_EN
         else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data_d    = '0;
            rsp_errors_d  = 2'd0;
            rsp_timeout_d = 1'b1;
            state_d       = RESP;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
`endif
         RESP: if (bus.rsp_ready) begin
`ifdef ECC_APB_MASTER_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered
      cmd_ready_d = (state_d == IDLE);
      psel_d      = (state_d == SETUP) || (state_d == ACCESS);
      penable_d   = (state_d == ACCESS);
      pwrite_d    = psel_d;
      rsp_valid_d = (state_d == RESP);
      paddr_d     = '0;
      pwdata_d    = '0;
      if (psel_d) begin
         case (idx_d)
            2'd0:    begin paddr_d = AMBA_ADDR_WIDTH'(4);  pwdata_d = data_d;              end
            2'd1:    begin paddr_d = AMBA_ADDR_WIDTH'(8);  pwdata_d = AMBA_WORD'(width_d); end
            2'd2:    begin paddr_d = AMBA_ADDR_WIDTH'(12); pwdata_d = noise_d;             end
            default: begin paddr_d = AMBA_ADDR_WIDTH'(0);  pwdata_d = AMBA_WORD'(op_d);    end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         cmd_ready_q  <= 1'b1;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_errors_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cmd_ready_q  <= cmd_ready_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_errors_q <= rsp_errors_d;
      end
   end

   // Captured command is only read after acceptance, so it needs no reset
   always_ff @(posedge clk) begin
      op_q    <= op_d;
      width_q <= width_d;
      data_q  <= data_d;
      noise_q <= noise_d;
   end

`ifdef ECC_APB_MASTER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end
`endif

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.PSEL       = psel_q;
   assign bus.PENABLE    = penable_q;
   assign bus.PWRITE     = pwrite_q;
   assign bus.PADDR      = paddr_q;
   assign bus.PWDATA     = pwdata_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_errors = rsp_errors_q;
endmodule

// File: tb/tb_ecc_apb_master.sv
// Bench for ecc_apb_master: directed job table, hand-written reset/timeout sequences and random jobs
// checked against a job-level model of the expected APB writes and response.
module tb_ecc_apb_master;
   localparam int DW = 32;
   localparam int AW = 20;
   localparam int WW = 32;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
   localparam int TCYC = 16;
`else
   localparam int TCYC = 64;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  width;
      logic [31:0] data;
      logic [31:0] noise;
      logic [31:0] dout;
      logic [1:0]  nerr;
      int          dly;
      int          bp;
      bit          stale;
      bit          hold;
   } job_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ecc_apb_master_if #(.DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW)) bus ();

   ecc_apb_master #(.DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW), .TIMEOUT_CYCLES(TCYC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] snap();
      return {7'd0, bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.PADDR, bus.PWDATA};
   endfunction

   function automatic logic [63:0] mk(bit cr, bit ps, bit pe, bit pw, bit rv, logic [19:0] a, logic [31:0] d);
      return {7'd0, cr, ps, pe, pw, rv, a, d};
   endfunction

   function automatic logic [63:0] rsnap();
      return {26'd0, bus.cmd_ready, bus.PSEL, bus.rsp_valid, bus.rsp_timeout, bus.rsp_errors, bus.rsp_data};
   endfunction

   function automatic logic [63:0] rmk(bit cr, bit rv, bit to, logic [1:0] e, logic [31:0] d);
      return {26'd0, cr, 1'b0, rv, to, e, d};
   endfunction

   // One job from an IDLE negedge to the negedge after the response handshake.
   task automatic do_job(input job_t j, input bit tmo);
      logic [19:0] exp_a[$];
      logic [31:0] exp_d[$];
      logic [19:0] a;
      logic [31:0] d;
      int          wait_cycles;
      exp_a = '{20'h4, 20'h8, 20'hC, 20'h0};
      exp_d = '{j.data, {30'd0, j.width}, j.noise, {30'd0, j.op}};
      bus.cmd_op = j.op; bus.cmd_width = j.width; bus.cmd_data = j.data; bus.cmd_noise = j.noise;
      bus.cmd_valid = 1'b1;
      chk("cmd_ready_idle", {63'd0, bus.cmd_ready}, 64'd1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.operation_done = 1'b0;
         if (k == 1) begin
            if (!j.hold) bus.cmd_valid = 1'b0;
            bus.cmd_data = $urandom; bus.cmd_noise = $urandom;
            bus.cmd_op = 2'($urandom); bus.cmd_width = 2'($urandom);
         end
         if (k % 2 == 1) begin
            a = exp_a.pop_front();
            d = exp_d.pop_front();
         end
         chk($sformatf("apb_k%0d", k), snap(), mk(0, 1, (k % 2 == 0), 1, 0, a, d));
         if (j.stale && k == 4) begin
            bus.operation_done = 1'b1;
            bus.data_out = $urandom; bus.num_of_errors = 2'd3;
         end
      end
      wait_cycles = tmo ? TCYC - 1 : j.dly;
      for (int w = 0; w <= wait_cycles; w++) begin
         @(negedge clk);
         bus.operation_done = 1'b0;
         chk("wait_done_idle", snap(), mk(0, 0, 0, 0, 0, 20'd0, 32'd0));
      end
      if (!tmo) begin
         bus.operation_done = 1'b1;
         bus.data_out = j.dout; bus.num_of_errors = j.nerr;
      end
      @(negedge clk);
      bus.operation_done = 1'b0;
      bus.data_out = $urandom; bus.num_of_errors = 2'($urandom);
      if (tmo) chk("rsp_timeout", rsnap(), rmk(0, 1, 1, 2'd0, 32'd0));
      else     chk("rsp_first", rsnap(), rmk(0, 1, 0, j.nerr, j.dout));
      for (int b = 0; b < j.bp; b++) begin
         @(negedge clk);
         if (tmo) chk("rsp_hold", rsnap(), rmk(0, 1, 1, 2'd0, 32'd0));
         else     chk("rsp_hold", rsnap(), rmk(0, 1, 0, j.nerr, j.dout));
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("rsp_accepted", {61'd0, bus.rsp_valid, bus.cmd_ready, bus.rsp_timeout}, {61'd0, 3'b010});
   endtask

   job_t tbl[6];
   job_t rj;

   initial begin
      tbl[0] = '{2'd0, 2'd0, 32'h0000_00A5, 32'h0,         32'h0000_01A5, 2'd0, 3, 0, 1'b0, 1'b0};
      tbl[1] = '{2'd1, 2'd1, 32'h0000_BEEF, 32'h0000_0010, 32'h0000_BEAF, 2'd1, 0, 5, 1'b0, 1'b0};
      tbl[2] = '{2'd2, 2'd2, 32'hDEAD_BEEF, 32'h8000_0001, 32'h1234_5678, 2'd2, 2, 0, 1'b1, 1'b0};
      tbl[3] = '{2'd1, 2'd2, 32'hCAFE_0001, 32'h0000_0004, 32'h0BAD_F00D, 2'd1, 1, 0, 1'b0, 1'b1};
      tbl[4] = '{2'd1, 2'd2, 32'hCAFE_0002, 32'h0000_0300, 32'h0BAD_F00E, 2'd2, 1, 1, 1'b0, 1'b0};
      tbl[5] = '{2'd3, 2'd1, 32'h5555_AAAA, 32'hFFFF_FFFF, 32'h0000_0077, 2'd3, 6, 2, 1'b0, 1'b0};

      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_width = 2'd0; bus.cmd_data = '0; bus.cmd_noise = '0;
      bus.operation_done = 1'b0; bus.data_out = '0; bus.num_of_errors = 2'd0; bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_apb", snap(), mk(1, 0, 0, 0, 0, 20'd0, 32'd0));
      chk("reset_rsp", rsnap(), rmk(1, 0, 0, 2'd0, 32'd0));

      // Stale done before any job must not produce a response
      bus.operation_done = 1'b1;
      @(negedge clk);
      bus.operation_done = 1'b0;
      @(negedge clk);
      chk("stale_idle", rsnap(), rmk(1, 0, 0, 2'd0, 32'd0));

      for (int i = 0; i < 6; i++) do_job(tbl[i], 1'b0);

      // Reset during the NOISE access phase
      bus.cmd_op = 2'd2; bus.cmd_width = 2'd1; bus.cmd_data = 32'h1111_2222; bus.cmd_noise = 32'h3333_4444;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("noise_access", snap(), mk(0, 1, 1, 1, 0, 20'hC, 32'h3333_4444));
      rst = 1'b1;
      @(negedge clk);
      chk("reset_mid_access", snap(), mk(1, 0, 0, 0, 0, 20'd0, 32'd0));
      rst = 1'b0;
      @(negedge clk);
      chk("after_reset_idle", rsnap(), rmk(1, 0, 0, 2'd0, 32'd0));

`ifdef ECC_APB_MASTER_TIMEOUT_EN
      rj = '{2'd3, 2'd0, 32'h0000_0042, 32'h0, 32'h0, 2'd0, 0, 2, 1'b0, 1'b0};
      do_job(rj, 1'b1);
`endif

      for (int i = 0; i < 20; i++) begin
         rj.op = 2'($urandom); rj.width = 2'($urandom_range(0, 2));
         rj.data = $urandom; rj.noise = $urandom; rj.dout = $urandom; rj.nerr = 2'($urandom);
         rj.dly = $urandom_range(0, 6); rj.bp = $urandom_range(0, 3);
         rj.stale = 1'($urandom); rj.hold = (i != 19) && ($urandom_range(0, 1) == 1);
         do_job(rj, 1'b0);
      end
      bus.cmd_valid = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
